// File: rtl/mem_stage.sv
// Memory stage of a simple in-order pipeline. It passes ALU results straight
// through to writeback and turns loads and stores into single-beat data-memory
// requests, with byte/half lane steering and load extension. Misaligned or
// illegal accesses never reach memory and come back as a faulting writeback.
// The byte-lane logic assumes DATA_MEM_WORD_SIZE = 32 (four byte lanes).
module mem_stage #(
  parameter int REGISTER_WIDTH     = 32,
  parameter int DATA_MEM_WORD_SIZE = 32
) (
  input  logic                          clk,
  input  logic                          rst_n,
  // execute-stage handshake and payload
  input  logic                          ex_valid,
  output logic                          ex_ready,
  input  logic [REGISTER_WIDTH-1:0]     ex_alu_out,
  input  logic [REGISTER_WIDTH-1:0]     ex_store_data,
  input  logic [1:0]                    ex_mem_op,
  input  logic [2:0]                    ex_funct3,
  input  logic [4:0]                    ex_rd,
  input  logic                          ex_reg_write,
  // data-memory port
  output logic                          dmem_req,
  output logic                          dmem_we,
  output logic [REGISTER_WIDTH-1:0]     dmem_addr,
  output logic [DATA_MEM_WORD_SIZE/8-1:0] dmem_be,
  output logic [DATA_MEM_WORD_SIZE-1:0] dmem_wdata,
  input  logic                          dmem_ready,
  input  logic [DATA_MEM_WORD_SIZE-1:0] dmem_rdata,
  // writeback
  output logic                          wb_valid,
  output logic [4:0]                    wb_rd,
  output logic [REGISTER_WIDTH-1:0]     wb_data,
  output logic                          wb_reg_write,
  output logic                          wb_fault
);

  localparam int BE_W = DATA_MEM_WORD_SIZE / 8;

  typedef enum logic {
    IDLE,
    ACCESS
  } state_t;

  state_t                         state_q, state_d;
  logic                           dmem_req_q, dmem_req_d;
  logic                           dmem_we_q, dmem_we_d;
  logic [REGISTER_WIDTH-1:0]      dmem_addr_q, dmem_addr_d;
  logic [BE_W-1:0]                dmem_be_q, dmem_be_d;
  logic [DATA_MEM_WORD_SIZE-1:0]  dmem_wdata_q, dmem_wdata_d;
  logic                           wb_valid_q, wb_valid_d;
  logic [4:0]                     wb_rd_q, wb_rd_d;
  logic [REGISTER_WIDTH-1:0]      wb_data_q, wb_data_d;
  logic                           wb_reg_write_q, wb_reg_write_d;
  logic                           wb_fault_q, wb_fault_d;
  logic [1:0]                     lo_q, lo_d;
  logic [2:0]                     funct3_q, funct3_d;
  logic [4:0]                     rd_q, rd_d;
  logic                           reg_write_q, reg_write_d;
  logic                           is_store_q, is_store_d;

  logic                           is_load, is_store, legal_load, legal_store;
  logic                           aligned, access_ok;
  logic [BE_W-1:0]                req_be;
  logic [DATA_MEM_WORD_SIZE-1:0]  req_wdata;
  logic [DATA_MEM_WORD_SIZE-1:0]  rdata_shifted;
  logic [REGISTER_WIDTH-1:0]      load_data;

  assign ex_ready = (state_q == IDLE);

  // Decode the presented instruction: access kind, funct3 legality and alignment.
  always_comb begin
    is_load     = (ex_mem_op == 2'b01);
    is_store    = (ex_mem_op == 2'b10);
    legal_load  = (ex_funct3 == 3'b000) || (ex_funct3 == 3'b001) || (ex_funct3 == 3'b010) ||
                  (ex_funct3 == 3'b100) || (ex_funct3 == 3'b101);
    legal_store = (ex_funct3 == 3'b000) || (ex_funct3 == 3'b001) || (ex_funct3 == 3'b010);
    case (ex_funct3[1:0])
      2'b00:   aligned = 1'b1;
      2'b01:   aligned = ~ex_alu_out[0];
      2'b10:   aligned = (ex_alu_out[1:0] == 2'b00);
      default: aligned = 1'b0;
    endcase
    access_ok = ((is_load && legal_load) || (is_store && legal_store)) && aligned;
  end

  // Steer store data onto the byte lanes and build the matching byte enables.
  always_comb begin
    case (ex_funct3[1:0])
      2'b00: begin
        req_be    = BE_W'(1) << ex_alu_out[1:0];
        req_wdata = {(DATA_MEM_WORD_SIZE/8){ex_store_data[7:0]}};
      end
      2'b01: begin
        req_be    = BE_W'(3) << ex_alu_out[1:0];
        req_wdata = {(DATA_MEM_WORD_SIZE/16){ex_store_data[15:0]}};
      end
      default: begin
        req_be    = '1;
        req_wdata = DATA_MEM_WORD_SIZE'(ex_store_data);
      end
    endcase
  end

  // Pick the addressed byte/half out of the returned word and extend it.
  always_comb begin
    rdata_shifted = dmem_rdata >> {lo_q, 3'b000};
    case (funct3_q)
      3'b000:  load_data = {{(REGISTER_WIDTH-8){rdata_shifted[7]}}, rdata_shifted[7:0]};
      3'b001:  load_data = {{(REGISTER_WIDTH-16){rdata_shifted[15]}}, rdata_shifted[15:0]};
      3'b100:  load_data = {{(REGISTER_WIDTH-8){1'b0}}, rdata_shifted[7:0]};
      3'b101:  load_data = {{(REGISTER_WIDTH-16){1'b0}}, rdata_shifted[15:0]};
      default: load_data = REGISTER_WIDTH'(rdata_shifted);
    endcase
  end

  // Next-state logic: accept in IDLE, hold the request in ACCESS until memory answers.
  always_comb begin
    state_d        = state_q;
    dmem_req_d     = dmem_req_q;
    dmem_we_d      = dmem_we_q;
    dmem_addr_d    = dmem_addr_q;
    dmem_be_d      = dmem_be_q;
    dmem_wdata_d   = dmem_wdata_q;
    wb_valid_d     = 1'b0;
    wb_rd_d        = wb_rd_q;
    wb_data_d      = wb_data_q;
    wb_reg_write_d = wb_reg_write_q;
    wb_fault_d     = wb_fault_q;
    lo_d           = lo_q;
    funct3_d       = funct3_q;
    rd_d           = rd_q;
    reg_write_d    = reg_write_q;
    is_store_d     = is_store_q;
    case (state_q)
      IDLE: begin
        if (ex_valid) begin
          if (!is_load && !is_store) begin
            wb_valid_d     = 1'b1;
            wb_data_d      = ex_alu_out;
            wb_rd_d        = ex_rd;
            wb_reg_write_d = ex_reg_write;
            wb_fault_d     = 1'b0;
          end else if (!access_ok) begin
            wb_valid_d     = 1'b1;
            wb_data_d      = ex_alu_out;
            wb_rd_d        = ex_rd;
            wb_reg_write_d = 1'b0;
            wb_fault_d     = 1'b1;
          end else begin
            state_d      = ACCESS;
            dmem_req_d   = 1'b1;
            dmem_we_d    = is_store;
            dmem_addr_d  = {ex_alu_out[REGISTER_WIDTH-1:2], 2'b00};
            dmem_be_d    = req_be;
            dmem_wdata_d = req_wdata;
            lo_d         = ex_alu_out[1:0];
            funct3_d     = ex_funct3;
            rd_d         = ex_rd;
            reg_write_d  = ex_reg_write;
            is_store_d   = is_store;
          end
        end
      end
      ACCESS: begin
        if (dmem_ready) begin
          state_d        = IDLE;
          dmem_req_d     = 1'b0;
          dmem_we_d      = 1'b0;
          dmem_be_d      = '0;
          wb_valid_d     = 1'b1;
          wb_rd_d        = rd_q;
          wb_data_d      = is_store_q ? '0 : load_data;
          wb_reg_write_d = reg_write_q && !is_store_q;
          wb_fault_d     = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs; reset abandons any outstanding access at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      dmem_req_q     <= 1'b0;
      dmem_we_q      <= 1'b0;
      dmem_addr_q    <= '0;
      dmem_be_q      <= '0;
      dmem_wdata_q   <= '0;
      wb_valid_q     <= 1'b0;
      wb_rd_q        <= '0;
      wb_data_q      <= '0;
      wb_reg_write_q <= 1'b0;
      wb_fault_q     <= 1'b0;
      lo_q           <= '0;
      funct3_q       <= '0;
      rd_q           <= '0;
      reg_write_q    <= 1'b0;
      is_store_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      dmem_req_q     <= dmem_req_d;
      dmem_we_q      <= dmem_we_d;
      dmem_addr_q    <= dmem_addr_d;
      dmem_be_q      <= dmem_be_d;
      dmem_wdata_q   <= dmem_wdata_d;
      wb_valid_q     <= wb_valid_d;
      wb_rd_q        <= wb_rd_d;
      wb_data_q      <= wb_data_d;
      wb_reg_write_q <= wb_reg_write_d;
      wb_fault_q     <= wb_fault_d;
      lo_q           <= lo_d;
      funct3_q       <= funct3_d;
      rd_q           <= rd_d;
      reg_write_q    <= reg_write_d;
      is_store_q     <= is_store_d;
    end
  end

  assign dmem_req     = dmem_req_q;
  assign dmem_we      = dmem_we_q;
  assign dmem_addr    = dmem_addr_q;
  assign dmem_be      = dmem_be_q;
  assign dmem_wdata   = dmem_wdata_q;
  assign wb_valid     = wb_valid_q;
  assign wb_rd        = wb_rd_q;
  assign wb_data      = wb_data_q;
  assign wb_reg_write = wb_reg_write_q;
  assign wb_fault     = wb_fault_q;

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: the driver pushes the expected writeback of
// every instruction it issues, a monitor pops and compares on each wb_valid,
// and a memory responder checks the request held during every access cycle.
module tb_mem_stage;

  logic        clk;
  logic        rst_n;
  logic        ex_valid;
  logic        ex_ready;
  logic [31:0] ex_alu_out;
  logic [31:0] ex_store_data;
  logic [1:0]  ex_mem_op;
  logic [2:0]  ex_funct3;
  logic [4:0]  ex_rd;
  logic        ex_reg_write;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_ready;
  logic [31:0] dmem_rdata;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        wb_reg_write;
  logic        wb_fault;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
    logic        rw;
    logic        fault;
    logic        check_data;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cycle  = 0;

  mem_stage #(.REGISTER_WIDTH(32), .DATA_MEM_WORD_SIZE(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_alu_out(ex_alu_out),
    .ex_store_data(ex_store_data), .ex_mem_op(ex_mem_op), .ex_funct3(ex_funct3),
    .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
    .dmem_wdata(dmem_wdata), .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .wb_reg_write(wb_reg_write), .wb_fault(wb_fault)
  );

  // Free-running clock and a cycle counter used to check writeback latency.
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: actual=0x%08h required=0x%08h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  // Reference model of a load: pick the addressed bytes by arithmetic and extend.
  function automatic logic [31:0] modelLoad(input logic [31:0] word, input logic [31:0] addr,
                                            input logic [2:0] f3);
    logic [31:0] v;
    int off;
    off = int'(addr % 4);
    case (f3)
      3'd0: begin v = (word / (32'd1 << (8 * off))) % 256;   if (v >= 128)   v = v - 256;   end
      3'd1: begin v = (word / (32'd1 << (8 * off))) % 65536; if (v >= 32768) v = v - 65536; end
      3'd4: v = (word / (32'd1 << (8 * off))) % 256;
      3'd5: v = (word / (32'd1 << (8 * off))) % 65536;
      default: v = word;
    endcase
    return v;
  endfunction

  // Issue one instruction, push its expected writeback and play the memory side.
  task automatic applyStimulus(input logic [1:0] op, input logic [2:0] f3, input logic [31:0] alu,
                               input logic [31:0] sd, input logic [4:0] rd, input logic rw,
                               input int n_access, input logic [31:0] rdata);
    exp_t e;
    int size, off;
    logic is_mem, legal, ok;
    logic [31:0] exp_be, exp_wd;
    ex_mem_op = op; ex_funct3 = f3; ex_alu_out = alu; ex_store_data = sd;
    ex_rd = rd; ex_reg_write = rw; ex_valid = 1'b1;
    dmem_ready = 1'($urandom_range(0, 1));
    dmem_rdata = $urandom;
    checkOutput("ex_ready_at_issue", {31'd0, ex_ready}, 32'd1);
    size   = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : (f3[1:0] == 2'd2) ? 4 : 0;
    is_mem = (op == 2'd1) || (op == 2'd2);
    legal  = (op == 2'd1) ? (f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5)
                          : (f3 == 0 || f3 == 1 || f3 == 2);
    ok     = is_mem && legal && (size != 0) && ((alu % size) == 0);
    off    = int'(alu % 4);
    exp_be = ((32'd1 << size) - 1) << off;
    exp_wd = (size == 1) ? (sd % 256) * 32'h01010101 :
             (size == 2) ? (sd % 65536) * 32'h00010001 : sd;
    e.rd = rd; e.data = alu; e.rw = rw; e.fault = 1'b0; e.check_data = 1'b1; e.cyc = cycle + 1;
    if (is_mem && !ok) begin
      e.fault = 1'b1; e.rw = 1'b0; e.check_data = 1'b0;
    end else if (ok) begin
      e.cyc        = cycle + 1 + n_access;
      e.rw         = (op == 2'd1) ? rw : 1'b0;
      e.check_data = (op == 2'd1);
      e.data       = modelLoad(rdata, alu, f3);
    end
    sb.push_back(e);
    @(posedge clk); #1;
    ex_valid = 1'b0;
    dmem_ready = 1'b0;
    if (ok) begin
      for (int k = 1; k <= n_access; k++) begin
        checkOutput("dmem_req_held", {31'd0, dmem_req}, 32'd1);
        checkOutput("dmem_we", {31'd0, dmem_we}, {31'd0, op == 2'd2});
        checkOutput("dmem_addr", dmem_addr, alu - (alu % 4));
        checkOutput("dmem_be", {28'd0, dmem_be}, exp_be);
        if (op == 2'd2) checkOutput("dmem_wdata", dmem_wdata, exp_wd);
        checkOutput("ex_ready_busy", {31'd0, ex_ready}, 32'd0);
        if (k == n_access) begin
          dmem_ready = 1'b1;
          dmem_rdata = rdata;
        end
        @(posedge clk); #1;
        dmem_ready = 1'b0;
        dmem_rdata = $urandom;
      end
    end else begin
      checkOutput("no_dmem_req", {31'd0, dmem_req}, 32'd0);
      checkOutput("dmem_be_idle", {28'd0, dmem_be}, 32'd0);
      checkOutput("ex_ready_stays", {31'd0, ex_ready}, 32'd1);
    end
  endtask

  // Monitor: every wb_valid must match the oldest outstanding expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && wb_valid) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_wb_valid: actual=1 required=0 (cycle %0d)", cycle);
        end else begin
          e = sb.pop_front();
          checkOutput("wb_latency", cycle, e.cyc);
          checkOutput("wb_fault", {31'd0, wb_fault}, {31'd0, e.fault});
          checkOutput("wb_reg_write", {31'd0, wb_reg_write}, {31'd0, e.rw});
          if (!e.fault) checkOutput("wb_rd", {27'd0, wb_rd}, {27'd0, e.rd});
          if (e.check_data) checkOutput("wb_data", wb_data, e.data);
        end
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [1:0]  op;
    logic [2:0]  f3;
    logic [31:0] a;
    rst_n = 1'b0; ex_valid = 1'b0; ex_alu_out = '0; ex_store_data = '0; ex_mem_op = '0;
    ex_funct3 = '0; ex_rd = '0; ex_reg_write = 1'b0; dmem_ready = 1'b0; dmem_rdata = '0;
    #12;
    checkOutput("rst_dmem_req", {31'd0, dmem_req}, 32'd0);
    checkOutput("rst_dmem_we", {31'd0, dmem_we}, 32'd0);
    checkOutput("rst_dmem_be", {28'd0, dmem_be}, 32'd0);
    checkOutput("rst_dmem_addr", dmem_addr, 32'd0);
    checkOutput("rst_dmem_wdata", dmem_wdata, 32'd0);
    checkOutput("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
    checkOutput("rst_wb_reg_write", {31'd0, wb_reg_write}, 32'd0);
    checkOutput("rst_wb_fault", {31'd0, wb_fault}, 32'd0);
    checkOutput("rst_wb_data", wb_data, 32'd0);
    checkOutput("rst_wb_rd", {27'd0, wb_rd}, 32'd0);
    checkOutput("rst_ex_ready", {31'd0, ex_ready}, 32'd1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    $display("[TB] directed cases");
    applyStimulus(2'b00, 3'b000, 32'h0000_1234, 32'h0, 5'd5, 1'b1, 1, 32'h0);
    applyStimulus(2'b01, 3'b000, 32'h0000_0103, 32'h0, 5'd6, 1'b1, 3, 32'h80FF_FFFF);
    applyStimulus(2'b01, 3'b100, 32'h0000_0103, 32'h0, 5'd7, 1'b1, 3, 32'h80FF_FFFF);
    applyStimulus(2'b10, 3'b001, 32'h0000_0202, 32'hABCD_1234, 5'd8, 1'b1, 1, 32'h0);
    applyStimulus(2'b01, 3'b010, 32'h0000_0101, 32'h0, 5'd9, 1'b1, 1, 32'h0);
    applyStimulus(2'b01, 3'b011, 32'h0000_0100, 32'h0, 5'd9, 1'b1, 1, 32'h0);
    applyStimulus(2'b10, 3'b100, 32'h0000_0100, 32'h0, 5'd9, 1'b1, 1, 32'h0);
    applyStimulus(2'b01, 3'b010, 32'hFFFF_FFFC, 32'h0, 5'd10, 1'b1, 2, 32'hDEAD_BEEF);
    applyStimulus(2'b10, 3'b010, 32'hFFFF_FFFC, 32'hCAFE_F00D, 5'd10, 1'b1, 11, 32'h0);
    applyStimulus(2'b11, 3'b010, 32'h0000_0101, 32'h0, 5'd11, 1'b1, 1, 32'h0);
    applyStimulus(2'b01, 3'b101, 32'h0000_0042, 32'h0, 5'd12, 1'b1, 1, 32'h1234_8765);
    applyStimulus(2'b01, 3'b001, 32'h0000_0042, 32'h0, 5'd13, 1'b0, 2, 32'h8765_1234);
    for (int i = 0; i < 4; i++)
      applyStimulus(2'b00, 3'b000, 32'h100 + i, 32'h0, 5'(i + 1), 1'b1, 1, 32'h0);

    $display("[TB] reset during access");
    ex_mem_op = 2'b01; ex_funct3 = 3'b010; ex_alu_out = 32'h0000_0400; ex_rd = 5'd3;
    ex_reg_write = 1'b1; ex_valid = 1'b1;
    @(posedge clk); #1;
    ex_valid = 1'b0;
    checkOutput("abort_req_before", {31'd0, dmem_req}, 32'd1);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    checkOutput("abort_req_dropped", {31'd0, dmem_req}, 32'd0);
    checkOutput("abort_be_cleared", {28'd0, dmem_be}, 32'd0);
    checkOutput("abort_no_wb_valid", {31'd0, wb_valid}, 32'd0);
    checkOutput("abort_ex_ready", {31'd0, ex_ready}, 32'd1);
    @(posedge clk); #1;
    dmem_ready = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    dmem_ready = 1'b0;
    @(posedge clk); #1;
    applyStimulus(2'b00, 3'b000, 32'h0000_5A5A, 32'h0, 5'd14, 1'b1, 1, 32'h0);

    $display("[TB] random cases");
    for (int i = 0; i < 200; i++) begin
      op = 2'($urandom_range(0, 3));
      f3 = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7))
                                         : 3'($urandom_range(0, 1) ? $urandom_range(0, 2)
                                                                    : $urandom_range(4, 5));
      a  = $urandom;
      if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
      applyStimulus(op, f3, a, $urandom, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
                    $urandom_range(1, 4), $urandom);
    end

    repeat (3) @(posedge clk);
    #1;
    checkOutput("scoreboard_drained", sb.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
